register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 91 +++++++++
 1 files changed

// File: rtl/register_file.sv
// Rename-aware architectural register file: 32 x (value, busy, ROB tag).
// Two combinational operand ports with same-cycle commit bypass.
module register_file #(
  parameter int ROB_ADDR = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  input  logic [ROB_ADDR-1:0] issue_rob,
  input  logic                commit_valid,
  input  logic [4:0]          commit_rd,
  input  logic [ROB_ADDR-1:0] commit_rob,
  input  logic [31:0]         commit_value,
  input  logic                flush_in,
  input  logic [4:0]          rs1_addr,
  input  logic [4:0]          rs2_addr,
  output logic                rs1_busy,
  output logic [ROB_ADDR-1:0] rs1_tag,
  output logic [31:0]         rs1_value,
  output logic                rs2_busy,
  output logic [ROB_ADDR-1:0] rs2_tag,
  output logic [31:0]         rs2_value
);

  localparam int RW = ROB_ADDR + 33;

  logic [31:0]         r_value [32];
  logic [ROB_ADDR-1:0] r_tag   [32];
  logic [31:0]         r_busy;

  logic [RW-1:0] w_rs1;
  logic [RW-1:0] w_rs2;

  logic w_commit_s;
  logic w_issue_s;

  assign w_commit_s = commit_valid && (commit_rd != 5'd0);
  assign w_issue_s  = issue_valid && !flush_in && (issue_rd != 5'd0);

  // Register state update: commit first, then flush or issue override busy/tag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        r_value[i] <= 32'd0;
        r_tag[i]   <= {ROB_ADDR{1'b0}};
      end
    end else if (rdy_in) begin
      if (w_commit_s) begin
        r_value[commit_rd] <= commit_value;
        // Only the rename that produced this commit may release the register.
        if (r_tag[commit_rd] == commit_rob) begin
          r_busy[commit_rd] <= 1'b0;
        end
      end
      if (flush_in) begin
        r_busy <= 32'd0;
      end else if (w_issue_s) begin
        r_busy[issue_rd] <= 1'b1;
        r_tag[issue_rd]  <= issue_rob;
      end
    end
  end

  // Operand lookup as {busy, tag, value}; x0 reads as all zero, matching commit bypasses.
  function automatic logic [RW-1:0] read_port(input logic [4:0] addr);
    logic [RW-1:0] res;
    if (addr == 5'd0) begin
      res = {RW{1'b0}};
    end else if (commit_valid && (commit_rd == addr) && r_busy[addr] &&
                 (r_tag[addr] == commit_rob)) begin
      res = {1'b0, r_tag[addr], commit_value};
    end else begin
      res = {r_busy[addr], r_tag[addr], r_value[addr]};
    end
    return res;
  endfunction

  assign w_rs1 = read_port(rs1_addr);
  assign w_rs2 = read_port(rs2_addr);

  assign rs1_busy  = w_rs1[RW-1];
  assign rs1_tag   = w_rs1[RW-2:32];
  assign rs1_value = w_rs1[31:0];
  assign rs2_busy  = w_rs2[RW-1];
  assign rs2_tag   = w_rs2[RW-2:32];
  assign rs2_value = w_rs2[31:0];

endmodule
